// File: rtl/i2c_sequencer_fsm_pkg.sv
// Shared definitions for the I2C transaction sequencer: one-hot state
// encoding and default sizing constants.
package i2c_sequencer_fsm_pkg;

    // One-hot encoding, matching the other I2C FSMs in this family.
    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_LAUNCH = 5'b00010,
        ST_ACTIVE = 5'b00100,
        ST_EVAL   = 5'b01000,
        ST_GAP    = 5'b10000
    } state_e;

    localparam int unsigned DEF_NUM_TRANS = 8;
    localparam int unsigned DEF_IDX_W     = 3;
    localparam int unsigned DEF_GAP_HIGHS = 5;
    localparam int unsigned DEF_GAP_W     = 6;
    localparam int unsigned DEF_MAX_RETRY = 2;
    localparam int unsigned DEF_RTY_W     = 2;

endpackage

// File: rtl/i2c_gap_counter.sv
// Counts cl_high strobes up to LIMIT and flags expiry; a synchronous clear
// restarts the count. Shared by the I2C FSMs that need SCL-high gaps.
module i2c_gap_counter #(
    parameter int unsigned CNT_W = 6,
    parameter int unsigned LIMIT = 5
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic strobe,
    output logic expired
);

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(LIMIT);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q == LIMIT_C);

    // NOTE: cnt_d gets its hold value first so no path leaves it unassigned,
    // which keeps the combinational block from inferring a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (strobe && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/i2c_sequencer_fsm.sv
// Launches NUM_TRANS back-to-back I2C transactions with SCL-high gaps,
// NACK retries and optional looping of the whole pass.
module i2c_sequencer_fsm
    import i2c_sequencer_fsm_pkg::*;
#(
    parameter int unsigned NUM_TRANS = DEF_NUM_TRANS,
    parameter int unsigned IDX_W     = DEF_IDX_W,
    parameter int unsigned GAP_HIGHS = DEF_GAP_HIGHS,
    parameter int unsigned GAP_W     = DEF_GAP_W,
    parameter int unsigned MAX_RETRY = DEF_MAX_RETRY,
    parameter int unsigned RTY_W     = DEF_RTY_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             loop_mode,
    input  logic             stop,
    input  logic             cl_high,
    input  logic             trans_done,
    input  logic             trans_nack,
    output logic             start_trans,
    output logic [IDX_W-1:0] trans_idx,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_TRANS - 1);
    localparam logic [RTY_W-1:0] RTY_LIMIT = RTY_W'(MAX_RETRY);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [RTY_W-1:0] rty_q, rty_d;
    logic             loop_q, loop_d;
    logic             nack_q, nack_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             gap_clear;
    logic             gap_expired;

    i2c_gap_counter #(
        .CNT_W (GAP_W),
        .LIMIT (GAP_HIGHS)
    ) u_gap_counter (
        .clock   (clock),
        .reset   (reset),
        .clear   (gap_clear),
        .strobe  (cl_high),
        .expired (gap_expired)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rty_d     = rty_q;
        loop_d    = loop_q;
        nack_d    = nack_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
        gap_clear = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    idx_d   = '0;
                    rty_d   = '0;
                    loop_d  = loop_mode;
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: state_d = ST_ACTIVE;
            ST_ACTIVE: begin
                if (trans_done) begin
                    nack_d  = trans_nack;
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                // Retry takes precedence; otherwise advance, wrap or finish.
                if (nack_q) begin
                    if (rty_q < RTY_LIMIT) begin
                        rty_d     = rty_q + 1'b1;
                        gap_clear = 1'b1;
                        state_d   = ST_GAP;
                    end else begin
                        error_d = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (idx_q < LAST_IDX) begin
                    idx_d     = idx_q + 1'b1;
                    rty_d     = '0;
                    gap_clear = 1'b1;
                    state_d   = ST_GAP;
                end else if (loop_q) begin
                    idx_d     = '0;
                    rty_d     = '0;
                    gap_clear = 1'b1;
                    state_d   = ST_GAP;
                end else begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_expired) begin
                    state_d = ST_LAUNCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // stop wins over a loop_mode sampled in the same cycle.
        if (stop) begin
            loop_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            rty_q   <= '0;
            loop_q  <= 1'b0;
            nack_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rty_q   <= rty_d;
            loop_q  <= loop_d;
            nack_q  <= nack_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign start_trans = (state_q == ST_LAUNCH);
    assign busy        = (state_q != ST_IDLE);
    assign trans_idx   = idx_q;
    assign done        = done_q;
    assign error       = error_q;

endmodule

// File: tb/tb_i2c_sequencer_fsm.sv
// Bench for i2c_sequencer_fsm: two instances (gap of 2 strobes, gap of 0)
// driven by a randomized transmitter/SCL stand-in and a transaction-level model.
module tb_i2c_sequencer_fsm;

    localparam int N  = 3;
    localparam int IW = 2;
    localparam int MR = 2;

    logic clock = 1'b0;
    logic reset, start, loop_mode, stop, cl_high, trans_done, trans_nack;

    logic          a_st, a_busy, a_done, a_err;
    logic [IW-1:0] a_idx;
    logic          b_st, b_busy, b_done, b_err;
    logic [IW-1:0] b_idx;

    logic          o_st, o_busy, o_done, o_err;
    logic [IW-1:0] o_idx;

    bit sel;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    i2c_sequencer_fsm #(
        .NUM_TRANS (N), .IDX_W (IW), .GAP_HIGHS (2), .GAP_W (3),
        .MAX_RETRY (MR), .RTY_W (2)
    ) dut_gap2 (
        .clock (clock), .reset (reset), .start (start), .loop_mode (loop_mode),
        .stop (stop), .cl_high (cl_high), .trans_done (trans_done),
        .trans_nack (trans_nack), .start_trans (a_st), .trans_idx (a_idx),
        .busy (a_busy), .done (a_done), .error (a_err)
    );

    i2c_sequencer_fsm #(
        .NUM_TRANS (N), .IDX_W (IW), .GAP_HIGHS (0), .GAP_W (1),
        .MAX_RETRY (MR), .RTY_W (2)
    ) dut_gap0 (
        .clock (clock), .reset (reset), .start (start), .loop_mode (loop_mode),
        .stop (stop), .cl_high (cl_high), .trans_done (trans_done),
        .trans_nack (trans_nack), .start_trans (b_st), .trans_idx (b_idx),
        .busy (b_busy), .done (b_done), .error (b_err)
    );

    assign o_st   = sel ? b_st   : a_st;
    assign o_busy = sel ? b_busy : a_busy;
    assign o_done = sel ? b_done : a_done;
    assign o_err  = sel ? b_err  : a_err;
    assign o_idx  = sel ? b_idx  : a_idx;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        start      = 1'b0;
        stop       = 1'b0;
        cl_high    = 1'b0;
        trans_done = 1'b0;
        trans_nack = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_start_trans"}, o_st, 0);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_done"}, o_done, 0);
        check({tag, "_error"}, o_err, 0);
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        step();
        step();
        check_quiet("reset");
        check("reset_idx", o_idx, 0);
        reset = 1'b0;
    endtask

    // Called at the sampling point of "cycle 0"; drives start there and then
    // plays transmitter and SCL source until the done/error pulse is seen.
    task automatic run_seq(input bit lp, input int nack_idx, input int nack_times,
                           input int stop_pass, input int exp_launches, input int exp_err);
        int g = sel ? 0 : 2;
        int exp_launch = 1, exp_end = -1, done_at = -1, gap_from = -1;
        int strobes = 0, m_idx = 0, m_rty = 0, pass = 1, nacks_left = nack_times;
        int launches = 0, hold_idx = 0;
        bit m_loop = lp, end_err = 1'b0, finished = 1'b0, stop_sent = 1'b0;
        bit nk, relaunch;

        clear_inputs();
        start     = 1'b1;
        loop_mode = lp;
        for (int cyc = 1; cyc <= 400 && !finished; cyc++) begin
            step();
            clear_inputs();
            check("start_trans", o_st, cyc == exp_launch);
            check("done", o_done, (cyc == exp_end) && !end_err);
            check("error", o_err, (cyc == exp_end) && end_err);
            check("busy", o_busy, cyc != exp_end);
            if (o_st) launches++;
            if (cyc == exp_launch) begin
                check("launch_idx", o_idx, m_idx);
                done_at    = cyc + int'($urandom_range(1, 3));
                exp_launch = -1;
                if (pass == stop_pass && m_idx == 0 && !stop_sent) begin
                    stop      = 1'b1;
                    stop_sent = 1'b1;
                    m_loop    = 1'b0;
                end
            end
            if (cyc == exp_end) begin
                check("end_idx", o_idx, hold_idx);
                finished = 1'b1;
            end else begin
                cl_high = ($urandom_range(0, 2) == 0);
                if ($urandom_range(0, 7) == 0) start = 1'b1;
                if (cyc == done_at) begin
                    nk         = (m_idx == nack_idx) && (nacks_left > 0);
                    trans_done = 1'b1;
                    trans_nack = nk;
                    relaunch   = 1'b1;
                    if (nk) begin
                        nacks_left--;
                        if (m_rty < MR) m_rty++;
                        else begin relaunch = 1'b0; end_err = 1'b1; end
                    end else if (m_idx < N - 1) begin
                        m_idx++;
                        m_rty = 0;
                    end else if (m_loop) begin
                        m_idx = 0;
                        m_rty = 0;
                        pass++;
                    end else begin
                        relaunch = 1'b0;
                        end_err  = 1'b0;
                    end
                    if (!relaunch) begin
                        exp_end  = cyc + 2;
                        hold_idx = m_idx;
                    end else if (g == 0) begin
                        exp_launch = cyc + 3;
                    end else begin
                        gap_from = cyc + 2;
                        strobes  = 0;
                    end
                end else if (gap_from >= 0 && cyc >= gap_from && $urandom_range(0, 3) == 0) begin
                    trans_done = 1'b1;
                    trans_nack = 1'($urandom_range(0, 1));
                end
                if (gap_from >= 0 && cyc >= gap_from) begin
                    if (cl_high) strobes++;
                    if (strobes == g) begin
                        exp_launch = cyc + 2;
                        gap_from   = -1;
                    end
                end
            end
        end
        check("seq_finished", finished, 1);
        if (exp_launches >= 0) check("launch_count", launches, exp_launches);
        if (exp_err >= 0) check("end_kind", end_err, exp_err);
    endtask

    initial begin
        reset     = 1'b1;
        loop_mode = 1'b0;
        sel       = 1'b0;
        clear_inputs();
        do_reset();

        // Gap of 2 strobes; each run starts in the cycle the previous one ends.
        run_seq(1'b0, -1, 0, 0, 3, 0);
        run_seq(1'b0, 1, 2, 0, 5, 0);
        run_seq(1'b0, 1, 3, 0, 4, 1);
        clear_inputs();
        trans_done = 1'b1;
        trans_nack = 1'b1;
        step();
        clear_inputs();
        check_quiet("post_error");
        check("post_error_idx", o_idx, 1);
        step();
        check_quiet("post_error2");
        check("post_error_idx2", o_idx, 1);
        run_seq(1'b1, -1, 0, 2, 6, 0);

        // Zero-strobe gap: relaunch three cycles after trans_done.
        sel = 1'b1;
        do_reset();
        run_seq(1'b0, -1, 0, 0, 3, 0);
        run_seq(1'b0, 2, 1, 0, 4, 0);

        // Reset while ACTIVE on idx 1, then trans_done while idle.
        do_reset();
        start = 1'b1;
        step(); clear_inputs();
        check("ra_launch0", o_st, 1);
        step(); trans_done = 1'b1;
        step(); clear_inputs();
        step();
        step();
        check("ra_launch1", o_st, 1);
        check("ra_idx1", o_idx, 1);
        step(); reset = 1'b1;
        step(); reset = 1'b0;
        check_quiet("ra");
        check("ra_idx", o_idx, 0);
        trans_done = 1'b1;
        trans_nack = 1'b1;
        step(); clear_inputs();
        check_quiet("ra_spurious");

        // Reset while in GAP on the two-strobe instance.
        sel = 1'b0;
        do_reset();
        start = 1'b1;
        step(); clear_inputs();
        step(); trans_done = 1'b1;
        step(); clear_inputs();
        step();
        check("rg_busy_in_gap", o_busy, 1);
        check("rg_no_launch", o_st, 0);
        reset = 1'b1;
        step(); reset = 1'b0;
        check_quiet("rg");
        check("rg_idx", o_idx, 0);
        step();
        check_quiet("rg_after");

        // Randomized plans on either instance.
        for (int k = 0; k < 6; k++) begin
            bit lp;
            sel = 1'($urandom_range(0, 1));
            lp  = 1'($urandom_range(0, 1));
            do_reset();
            run_seq(lp, int'($urandom_range(0, 3)) - 1, int'($urandom_range(0, 3)),
                    lp ? int'($urandom_range(1, 2)) : 0, -1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
